cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_pkg.sv | 69 ++++++
 rtl/cpu_control_unit_pc_sequencer.sv | 41 ++++
 rtl/cpu_control_unit.sv | 171 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU encodings,
// FSM state enum, instruction field positions and the opcode decoder.
package cpu_pkg;

    // Opcodes (INSTR[31:24])
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    // ALU operation encodings
    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    // Instruction field positions
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    // Per-instruction control bundle produced by the decoder
    typedef struct packed {
        logic       imm_sel;
        logic       neg_sel;
        logic [2:0] aluop;
        logic       write;
        logic       illegal;
        logic       jump;
        logic       branch;
    } ctrl_t;

    // Map an opcode to its control bundle; anything undefined is flagged illegal
    function automatic ctrl_t decode_op(input logic [7:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LOADI: begin c.imm_sel = 1'b1; c.aluop = ALU_FWD; c.write = 1'b1; end
            OP_MOV:   begin c.aluop = ALU_FWD; c.write = 1'b1; end
            OP_ADD:   begin c.aluop = ALU_ADD; c.write = 1'b1; end
            OP_SUB:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.write = 1'b1; end
            OP_AND:   begin c.aluop = ALU_AND; c.write = 1'b1; end
            OP_OR:    begin c.aluop = ALU_OR;  c.write = 1'b1; end
            OP_J:     begin c.jump = 1'b1; end
            OP_BEQ:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.branch = 1'b1; end
            default:  begin c.illegal = 1'b1; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_unit_pc_sequencer.sv
// Program counter register and next-PC adder. PC advances by one word, plus
// a signed 8-bit word offset when a branch is taken; arithmetic wraps at
// 2^ADDR_W.
module pc_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_en,
    input  logic              i_branch_taken,
    input  logic [7:0]        i_offset,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_offset_ext;
    logic [ADDR_W-1:0] w_next_pc;

    // Sign-extend the word offset to the PC width
    assign w_offset_ext = ADDR_W'($signed(i_offset));

    // Next PC: PC+1, plus the offset when taken; natural wrap at ADDR_W bits
    always_comb begin
        w_next_pc = r_pc + ADDR_W'(1);
        if (i_branch_taken) begin
            w_next_pc = r_pc + ADDR_W'(1) + w_offset_ext;
        end
    end

    // PC register, loaded only when the controller retires an instruction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (i_load_en) begin
            r_pc <= w_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control unit: fetch / decode / execute / writeback FSM,
// instruction register, registered control decode and fetch-timeout fault.
// IMEM handshake: INSTR is taken on a clock edge where IMEM_REQ and
// IMEM_READY are both high; IMEM_REQ is high for every FETCH cycle and
// IMEM_READY is ignored in every other state.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_READY,
    input  logic [31:0]       INSTR,
    input  logic              ZERO,
    output logic [2:0]        READREG1,
    output logic [2:0]        READREG2,
    output logic [2:0]        WRITEREG,
    output logic [7:0]        IMMEDIATE,
    output logic              IMM_SEL,
    output logic              NEG_SEL,
    output logic [2:0]        ALUOP,
    output logic              WRITE_EN,
    output logic [ADDR_W-1:0] PC,
    output logic              ILLEGAL,
    output logic              FAULT,
    output logic [2:0]        DBG_STATE
);

    localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_ir;
    logic [WAIT_W-1:0] r_wait;
    logic              r_fault;
    logic              r_zero;
    ctrl_t             r_ctrl;
    ctrl_t             w_dec;
    logic [2:0]        r_rr1;
    logic [2:0]        r_rr2;
    logic [2:0]        r_wr;
    logic [7:0]        r_imm;
    logic [7:0]        r_offset;
    logic              w_timeout;
    logic              w_load_en;
    logic              w_taken;
    logic [ADDR_W-1:0] w_pc;
    logic              w_unused_src1_hi;

    // Only the low 3 bits of SRC1 address the register file
    assign w_unused_src1_hi = ^r_ir[15:11];

    // Last permitted wait cycle in FETCH
    assign w_timeout = (r_wait == WAIT_W'(IMEM_TIMEOUT - 1));

    assign w_dec = decode_op(r_ir[OP_MSB:OP_LSB]);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed 4-cycle sequence, FETCH may stall or time out
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (IMEM_READY) begin
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_DECODE:    w_next_state = ST_EXECUTE;
            ST_EXECUTE:   w_next_state = ST_WRITEBACK;
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_HALT:      w_next_state = ST_HALT;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Fetch wait counter and sticky timeout fault
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else if (r_state == ST_FETCH && !IMEM_READY) begin
            if (w_timeout) begin
                r_fault <= 1'b1;
            end else begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end else begin
            r_wait <= '0;
        end
    end

    // Instruction register, captured on the accepting fetch edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ir <= '0;
        end else if (r_state == ST_FETCH && IMEM_READY) begin
            r_ir <= INSTR;
        end
    end

    // Control outputs registered in DECODE, held through EXECUTE/WRITEBACK;
    // ZERO is sampled at the end of EXECUTE for BEQ
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ctrl   <= '0;
            r_rr1    <= '0;
            r_rr2    <= '0;
            r_wr     <= '0;
            r_imm    <= '0;
            r_offset <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_ctrl   <= w_dec;
                r_rr1    <= r_ir[SRC1_LSB +: 3];
                r_rr2    <= r_ir[SRC2_LSB +: 3];
                r_wr     <= r_ir[DEST_LSB +: 3];
                r_imm    <= r_ir[SRC2_MSB:SRC2_LSB];
                r_offset <= r_ir[DEST_MSB:DEST_LSB];
            end
            if (r_state == ST_EXECUTE) begin
                r_zero <= ZERO;
            end
        end
    end

    assign w_load_en = (r_state == ST_WRITEBACK);
    assign w_taken   = r_ctrl.jump | (r_ctrl.branch & r_zero);

    pc_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_pc_seq (
        .i_clk          (CLK),
        .i_rst_n        (RESET),
        .i_load_en      (w_load_en),
        .i_branch_taken (w_taken),
        .i_offset       (r_offset),
        .o_pc           (w_pc)
    );

    assign IMEM_REQ  = (r_state == ST_FETCH);
    assign IMEM_ADDR = w_pc;
    assign PC        = w_pc;
    assign READREG1  = r_rr1;
    assign READREG2  = r_rr2;
    assign WRITEREG  = r_wr;
    assign IMMEDIATE = r_imm;
    assign IMM_SEL   = r_ctrl.imm_sel;
    assign NEG_SEL   = r_ctrl.neg_sel;
    assign ALUOP     = r_ctrl.aluop;
    assign WRITE_EN  = w_load_en & r_ctrl.write;
    assign ILLEGAL   = w_load_en & r_ctrl.illegal;
    assign FAULT     = r_fault;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction memory with programmable ready
// delay, an instruction-level reference model checked every cycle, and
// directed scenarios with literal expectations.
module tb_cpu_control_unit;
    import cpu_pkg::*;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IMEM_REQ;
    logic [7:0]  IMEM_ADDR;
    logic        IMEM_READY;
    logic [31:0] INSTR;
    logic        ZERO;
    logic [2:0]  READREG1, READREG2, WRITEREG;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, NEG_SEL;
    logic [2:0]  ALUOP;
    logic        WRITE_EN;
    logic [7:0]  PC;
    logic        ILLEGAL, FAULT;
    logic [2:0]  DBG_STATE;

    cpu_control_unit #(.ADDR_W(8), .IMEM_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READY(IMEM_READY), .INSTR(INSTR), .ZERO(ZERO),
        .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
        .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
        .ALUOP(ALUOP), .WRITE_EN(WRITE_EN), .PC(PC), .ILLEGAL(ILLEGAL),
        .FAULT(FAULT), .DBG_STATE(DBG_STATE)
    );

    // Clock
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] imem [256];
    int rdy_mode  = 0;   // 0: always ready, 1: ready after rdy_delay waits, 2: never
    int rdy_delay = 0;
    int req_run   = 0;

    // Reference model state
    int          m_stage = -2;   // -2 idle after reset, -1 fetching, 1..3 in flight
    logic [7:0]  m_pc    = 8'h00;
    logic [31:0] m_ir    = 32'h0;
    logic        m_zero  = 1'b0;
    logic        m_fault = 1'b0;
    int          m_wait  = 0;
    logic        exp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] model_aluop(input logic [7:0] op);
        if (op == 8'h02 || op == 8'h03 || op == 8'h07) return 3'd1;
        if (op == 8'h04) return 3'd2;
        if (op == 8'h05) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [31:0] ir,
                                                 input logic z);
        logic [7:0] op;
        logic [7:0] off;
        op  = ir[31:24];
        off = ir[23:16];
        if (op == 8'h06 || (op == 8'h07 && z)) return pc + 8'd1 + off;
        return pc + 8'd1;
    endfunction

    // Instruction memory: responds after each rising edge
    always @(posedge CLK) begin
        #1;
        if (IMEM_REQ) begin
            INSTR = imem[IMEM_ADDR];
            IMEM_READY = (rdy_mode == 0) || (rdy_mode == 1 && req_run >= rdy_delay);
            req_run++;
        end else begin
            req_run = 0;
            INSTR = $urandom();
            IMEM_READY = (rdy_mode == 0);
        end
    end

    // Compare process: instruction-level model checked on every falling edge
    always @(negedge CLK) begin
        if (!RESET) begin
            m_stage = -2; m_pc = 8'h00; m_fault = 1'b0; m_wait = 0; cyc = 0;
        end else begin
            cyc++;
            exp_req = (m_stage == -1) && !m_fault;
            chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", {24'b0, IMEM_ADDR}, {24'b0, m_pc});
            chk("pc", {24'b0, PC}, {24'b0, m_pc});
            chk("fault", {31'b0, FAULT}, {31'b0, m_fault});
            if (m_stage >= 2) begin
                chk("imm_sel",  {31'b0, IMM_SEL},  {31'b0, m_ir[31:24] == 8'h00});
                chk("neg_sel",  {31'b0, NEG_SEL},
                    {31'b0, m_ir[31:24] == 8'h03 || m_ir[31:24] == 8'h07});
                chk("aluop",    {29'b0, ALUOP},    {29'b0, model_aluop(m_ir[31:24])});
                chk("readreg1", {29'b0, READREG1}, {29'b0, m_ir[10:8]});
                chk("readreg2", {29'b0, READREG2}, {29'b0, m_ir[2:0]});
                chk("writereg", {29'b0, WRITEREG}, {29'b0, m_ir[18:16]});
                chk("immediate", {24'b0, IMMEDIATE}, {24'b0, m_ir[7:0]});
            end
            chk("write_en", {31'b0, WRITE_EN}, {31'b0, m_stage == 3 && m_ir[31:24] <= 8'h05});
            chk("illegal",  {31'b0, ILLEGAL},  {31'b0, m_stage == 3 && m_ir[31:24] > 8'h07});
            if (m_stage == 2) m_zero = ZERO;
            if (m_stage == 3) begin
                m_pc = model_next_pc(m_pc, m_ir, m_zero);
                m_stage = -1;
            end else if (m_stage >= 1) begin
                m_stage++;
            end else if (m_stage == -2) begin
                m_stage = -1;
            end else if (exp_req) begin
                if (IMEM_READY) begin
                    m_ir = imem[m_pc]; m_stage = 1; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) m_fault = 1'b1;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 300) begin
            @(negedge CLK); #2;
            guard++;
        end
        if (cyc < n) begin
            total++; bad++;
            $display("FAIL wait_cyc: got=%0d want=%0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        chk("rst_imem_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_write_en", {31'b0, WRITE_EN}, 32'd0);
        chk("rst_pc",       {24'b0, PC},       32'd0);
        chk("rst_fault",    {31'b0, FAULT},    32'd0);
        chk("rst_aluop",    {29'b0, ALUOP},    32'd0);
        chk("rst_state",    {29'b0, DBG_STATE}, {29'b0, ST_IDLE});
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0100_0000;
    endtask

    int we_cyc[$];
    int cnt;

    initial begin
        RESET = 1'b0; IMEM_READY = 1'b0; INSTR = 32'h0; ZERO = 1'b0;
        clear_imem();

        // LOADI r1,5; LOADI r2,3; SUB r3,r1,r2 with ready tied high
        imem[0] = 32'h00_01_00_05;
        imem[1] = 32'h00_02_00_03;
        imem[2] = 32'h03_03_01_02;
        rdy_mode = 0;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            wait_cyc(k);
            if (WRITE_EN) we_cyc.push_back(cyc);
            if (k == 2) chk("first_req_cyc2", {31'b0, IMEM_REQ}, 32'd1);
            if (k == 13) begin
                chk("sub_neg_sel",  {31'b0, NEG_SEL},  32'd1);
                chk("sub_aluop",    {29'b0, ALUOP},    32'd1);
                chk("sub_writereg", {29'b0, WRITEREG}, 32'd3);
            end
        end
        chk("prog_pc", {24'b0, PC}, 32'd3);
        chk("we_count", we_cyc.size(), 32'd3);
        chk("we_cyc0", we_cyc[0], 32'd5);
        chk("we_cyc1", we_cyc[1], 32'd9);
        chk("we_cyc2", we_cyc[2], 32'd13);

        // BEQ -2 at PC=4, taken then not taken
        clear_imem();
        imem[0] = 32'h04_05_01_02;
        imem[1] = 32'h05_06_01_02;
        imem[2] = 32'h02_07_01_02;
        imem[3] = 32'h00_01_00_11;
        imem[4] = 32'h07_FE_01_02;
        for (int z = 1; z >= 0; z--) begin
            ZERO = z[0];
            do_reset();
            wait_cyc(21);
            chk("beq_rr1", {29'b0, READREG1}, 32'd1);
            chk("beq_rr2", {29'b0, READREG2}, 32'd2);
            chk("beq_we",  {31'b0, WRITE_EN}, 32'd0);
            wait_cyc(22);
            chk("beq_pc", {24'b0, PC}, (z == 1) ? 32'd3 : 32'd5);
        end
        ZERO = 1'b0;

        // J -2 from 0 wraps to 0xFF, then J +1 from 0xFF wraps to 0x01
        clear_imem();
        imem[0]   = 32'h06_FE_00_00;
        imem[255] = 32'h06_01_00_00;
        do_reset();
        wait_cyc(6);
        chk("j_back_pc", {24'b0, PC}, 32'hFF);
        wait_cyc(10);
        chk("j_wrap_pc", {24'b0, PC}, 32'h01);

        // Ready delayed 3 cycles: request held 4 cycles on a stable address
        clear_imem();
        imem[0] = 32'h00_04_00_2C;
        rdy_mode = 1; rdy_delay = 3;
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(k);
            if (IMEM_REQ) begin
                cnt++;
                chk("delay_addr", {24'b0, IMEM_ADDR}, 32'd0);
            end
            if (k == 8) chk("delay_we", {31'b0, WRITE_EN}, 32'd1);
        end
        chk("delay_req_len", cnt, 32'd4);

        // Ready never arrives: fault after 15 wait cycles, stuck in HALT
        rdy_mode = 2;
        do_reset();
        wait_cyc(16);
        chk("to_fault_early", {31'b0, FAULT}, 32'd0);
        wait_cyc(17);
        chk("to_fault", {31'b0, FAULT}, 32'd1);
        chk("to_halt",  {29'b0, DBG_STATE}, {29'b0, ST_HALT});
        rdy_mode = 0;
        wait_cyc(22);
        chk("halt_stays", {29'b0, DBG_STATE}, {29'b0, ST_HALT});
        chk("halt_no_req", {31'b0, IMEM_REQ}, 32'd0);

        // Undefined opcode 0x2A
        clear_imem();
        imem[0] = 32'h2A_01_01_01;
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            wait_cyc(k);
            if (ILLEGAL) cnt++;
        end
        chk("illegal_pulses", cnt, 32'd1);
        chk("illegal_pc", {24'b0, PC}, 32'd1);

        // Reset during writeback of ADD at PC=1
        clear_imem();
        imem[0] = 32'h00_01_00_07;
        imem[1] = 32'h02_03_01_02;
        do_reset();
        wait_cyc(9);
        chk("add_wb_we", {31'b0, WRITE_EN}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("abort_we",    {31'b0, WRITE_EN}, 32'd0);
        chk("abort_pc",    {24'b0, PC},       32'd0);
        chk("abort_state", {29'b0, DBG_STATE}, {29'b0, ST_IDLE});
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        wait_cyc(2);
        chk("restart_req",  {31'b0, IMEM_REQ},  32'd1);
        chk("restart_addr", {24'b0, IMEM_ADDR}, 32'd0);
        wait_cyc(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
